// File: rtl/bit_split_32_pkg.sv
// Shared definitions for the bit splitter: widths, FSM encoding, beat payload.
package bit_split_32_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned IDX_W = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } state_t;

   // One emitted beat as seen downstream.
   typedef struct packed {
      logic [WIDTH-1:0] onehot;
      logic [IDX_W-1:0] index;
      logic             last;
   } beat_t;

endpackage : bit_split_32_pkg

// File: rtl/bit_split_32_if.sv
// Word-in / beat-out handshake bundle for bit_split_32.
// slave: the splitter itself; master: whoever feeds words and consumes beats.
interface bit_split_32_if;
   import bit_split_32_pkg::*;

   logic [WIDTH-1:0] in_word;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_onehot;
   logic [IDX_W-1:0] out_index;
   logic             out_last;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport slave (
      input  in_word, in_valid, out_ready,
      output in_ready, out_onehot, out_index, out_last, out_valid, busy
   );

   modport master (
      output in_word, in_valid, out_ready,
      input  in_ready, out_onehot, out_index, out_last, out_valid, busy
   );

endinterface : bit_split_32_if

// File: rtl/bit_split_32_prio_enc.sv
// prio_enc_32: combinational priority encoder picking one set bit of a word.
// Default picks the lowest set bit; with BIT_SPLIT_MSB_FIRST_EN defined it
// picks the highest. An all-zero input gives onehot=0, index=0, any=0.
module prio_enc_32
   import bit_split_32_pkg::*;
(
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   // Scan so the last hit written is the bit with the highest priority.
   always_comb begin
      index = '0;
`ifdef BIT_SPLIT_MSB_FIRST_EN
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (vec[i]) index = IDX_W'(i);
      end
`else
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (vec[i]) index = IDX_W'(i);
      end
`endif
      any    = |vec;
      onehot = any ? (WIDTH'(1) << index) : '0;
   end

endmodule : prio_enc_32

// File: rtl/bit_split_32.sv
// bit_split_32: emits each set bit of an accepted 32-bit word as its own
// one-hot beat, one beat per cycle under valid/ready. A zero word yields a
// single empty beat flagged last so frame boundaries are always visible.
// Build option: BIT_SPLIT_MSB_FIRST_EN emits the highest set bit first.
module bit_split_32
   import bit_split_32_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   bit_split_32_if.slave  bus
);

   state_t           state;
   logic [WIDTH-1:0] residual;

   logic [WIDTH-1:0] enc_onehot;
   logic [IDX_W-1:0] enc_index;
   logic             enc_any;
   logic             last_c;
   logic             split_c;
   beat_t            beat_c;

   prio_enc_32 u_prio_enc (
      .vec    (residual),
      .onehot (enc_onehot),
      .index  (enc_index),
      .any    (enc_any)
   );

   // Last beat: the frame is empty or only the selected bit remains.
   always_comb begin
      split_c = (state == ST_SPLIT);
      last_c  = !enc_any || ((residual & ~enc_onehot) == '0);
   end

   // FSM and residual register; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         residual <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  residual <= bus.in_word;
                  state    <= ST_SPLIT;
               end
            end
            ST_SPLIT: begin
               if (bus.out_ready) begin
                  residual <= residual & ~enc_onehot;
                  if (last_c) state <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               residual <= '0;
            end
         endcase
      end
   end

   // Beat payload is forced to zero outside a frame.
   always_comb begin
      beat_c = '0;
      if (split_c) begin
         beat_c.onehot = enc_onehot;
         beat_c.index  = enc_index;
         beat_c.last   = last_c;
      end
   end

   // Handshake/status outputs depend on registered state only.
   always_comb begin
      bus.in_ready   = !split_c;
      bus.out_valid  = split_c;
      bus.busy       = split_c;
      bus.out_onehot = beat_c.onehot;
      bus.out_index  = beat_c.index;
      bus.out_last   = beat_c.last;
   end

endmodule : bit_split_32

// File: tb/tb_bit_split_32.sv
// Scoreboard bench for bit_split_32: a reference model expands each accepted
// word into its expected beat list; a monitor pops and compares every beat.
module tb_bit_split_32;
   import bit_split_32_pkg::*;

   typedef struct {
      logic [31:0] oh;
      logic [4:0]  idx;
      logic        last;
   } exp_beat_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bit_split_32_if bus ();

   bit_split_32 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   exp_beat_t   exp_q[$];
   logic [31:0] word_q[$];

   logic ready_force;
   logic ready_val;
   logic rnd_ready;
   assign bus.out_ready = ready_force ? ready_val : rnd_ready;

   always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: set bits in emission order, last on the final one; zero word -> one empty beat.
   function automatic void model(input logic [31:0] w);
      int n;
      int seen;
      exp_beat_t b;
      n    = $countones(w);
      seen = 0;
      if (w == 32'h0) begin
         b.oh = 32'h0; b.idx = 5'd0; b.last = 1'b1;
         exp_q.push_back(b);
      end else begin
         for (int k = 0; k < 32; k++) begin
            int i;
`ifdef BIT_SPLIT_MSB_FIRST_EN
            i = 31 - k;
`else
            i = k;
`endif
            if (w[i]) begin
               seen++;
               b.oh   = 32'h1 << i;
               b.idx  = 5'(i);
               b.last = (seen == n);
               exp_q.push_back(b);
            end
         end
      end
      word_q.push_back(w);
   endfunction

   // Monitor: score each handshaked beat, frame OR / beat count, and hold stability.
   logic [31:0] acc;
   int          nbeats;
   logic        held;
   exp_beat_t   held_b;
   initial begin
      acc = '0; nbeats = 0; held = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            acc = '0; nbeats = 0; held = 1'b0;
         end else begin
            if (held && bus.out_valid) begin
               check("hold_onehot", bus.out_onehot, held_b.oh);
               check("hold_index", 32'(bus.out_index), 32'(held_b.idx));
               check("hold_last", 32'(bus.out_last), 32'(held_b.last));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_beat: got onehot %h with no beat expected", bus.out_onehot);
               end else begin
                  exp_beat_t b;
                  b = exp_q.pop_front();
                  check("beat_onehot", bus.out_onehot, b.oh);
                  check("beat_index", 32'(bus.out_index), 32'(b.idx));
                  check("beat_last", 32'(bus.out_last), 32'(b.last));
                  acc |= bus.out_onehot;
                  nbeats++;
                  if (bus.out_last && word_q.size() != 0) begin
                     logic [31:0] w;
                     int ecount;
                     w = word_q.pop_front();
                     ecount = (w == 32'h0) ? 1 : $countones(w);
                     check("frame_or", acc, w);
                     check("frame_beats", 32'(nbeats), 32'(ecount));
                     acc = '0; nbeats = 0;
                  end
               end
            end
            held = bus.out_valid && !bus.out_ready;
            held_b.oh   = bus.out_onehot;
            held_b.idx  = bus.out_index;
            held_b.last = bus.out_last;
         end
      end
   end

   task automatic check_reset_vals();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_onehot", bus.out_onehot, 32'h0);
      check("rst_out_index", 32'(bus.out_index), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
   endtask

   // Offer a word once in_ready is seen; returns just after the accepting edge.
   task automatic send_word(input logic [31:0] w);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stuck at %b, required 1", bus.in_ready);
      end
      bus.in_word  = w;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_word  = $urandom;
      model(w);
   endtask

   // Count edges after the accept until in_ready is back.
   task automatic wait_ready(output int n);
      n = 0;
      forever begin
         @(posedge clk);
         n++;
         #1;
         if (bus.in_ready) break;
         if (n >= 200) begin
            checks++; errors++;
            $display("FAIL ready_timeout: in_ready still %b after %0d cycles, required 1", bus.in_ready, n);
            break;
         end
      end
   endtask

   initial begin
      int n;
      logic [31:0] w;

      reset        = 1'b1;
      bus.in_word  = '0;
      bus.in_valid = 1'b0;
      ready_force  = 1'b1;
      ready_val    = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals();

      // Three set bits: three beats, next accept one cycle after the last beat.
      send_word(32'h8000_0011);
      wait_ready(n);
      check("lat_three_bits", 32'(n), 32'd3);

      // Zero word: single empty beat.
      send_word(32'h0000_0000);
      wait_ready(n);
      check("lat_zero_word", 32'(n), 32'd1);

      // All ones: 32 beats back to back.
      send_word(32'hFFFF_FFFF);
      wait_ready(n);
      check("lat_all_ones", 32'(n), 32'd32);

      // Backpressure: first beat must hold for three stalled cycles.
      ready_val = 1'b0;
      send_word(32'h0000_0006);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
`ifdef BIT_SPLIT_MSB_FIRST_EN
         check("bp_onehot", bus.out_onehot, 32'h4);
         check("bp_index", 32'(bus.out_index), 32'd2);
`else
         check("bp_onehot", bus.out_onehot, 32'h2);
         check("bp_index", 32'(bus.out_index), 32'd1);
`endif
      end
      @(posedge clk);
      #1 ready_val = 1'b1;
      wait_ready(n);

      // Reset mid-frame after one consumed beat: rest of frame is dropped.
      send_word(32'h0000_00F0);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      ready_val = 1'b0;
      exp_q.delete();
      word_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals();
      ready_val = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_idle", 32'(bus.out_valid), 32'd0);
      send_word(32'h0000_0001);
      wait_ready(n);
      check("lat_single_bit", 32'(n), 32'd1);

      // Random words with random downstream stalls.
      ready_force = 1'b0;
      for (int k = 0; k < 40; k++) begin
         case (k % 8)
            0:       w = 32'h0;
            1:       w = 32'hFFFF_FFFF;
            2:       w = 32'h1 << $urandom_range(0, 31);
            3:       w = $urandom & $urandom & $urandom;
            default: w = $urandom;
         endcase
         send_word(w);
         wait_ready(n);
      end
      ready_force = 1'b1;
      ready_val   = 1'b1;
      repeat (4) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("frames_drained", 32'(word_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bit_split_32
